// File: rtl/ram_sdp_sched_pkg.sv
// Shared types and the round-robin search used by both arbiters of ram_sdp_sched.
// Tag indices are IDX_MAX_W bits wide, so NUM_REQ may not exceed MAX_REQ.
package ram_sdp_sched_pkg;

    localparam int unsigned IDX_MAX_W = 4;
    localparam int unsigned MAX_REQ   = 16;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } tag_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                      input logic [IDX_MAX_W-1:0] ptr,
                                      input int unsigned          n);
        pick_t       res;
        int unsigned raw;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            raw  = 32'(ptr) + i;
            cand = (raw >= n) ? (raw - n) : raw;
            if ((i < n) && !res.found && req[cand[IDX_MAX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sdp_sched_if.sv
// Requester-side bus of ram_sdp_sched: write/read request channels and read responses.
interface ram_sdp_sched_if #(
    parameter int NUM_REQ  = 4,
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int BYTE_NUM = 4
);
    logic [NUM_REQ-1:0]          wr_valid_i;
    logic [NUM_REQ-1:0]          wr_ready_o;
    logic [NUM_REQ*AW-1:0]       wr_addr_i;
    logic [NUM_REQ*DW-1:0]       wr_data_i;
    logic [NUM_REQ*BYTE_NUM-1:0] wr_be_i;
    logic [NUM_REQ-1:0]          rd_valid_i;
    logic [NUM_REQ-1:0]          rd_ready_o;
    logic [NUM_REQ*AW-1:0]       rd_addr_i;
    logic [NUM_REQ-1:0]          rsp_valid_o;
    logic [DW-1:0]               rsp_data_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, rd_valid_i, rd_addr_i,
        input  wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, rd_valid_i, rd_addr_i,
        output wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/ram_sdp_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the pointer, pointer moves
// past the winner only when a grant is actually issued (en_i high).
module rr_arbiter
    import ram_sdp_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        ptr_d;
    logic [MAX_REQ-1:0]   req_ext_s;
    pick_t                pick_s;
    logic [IW-1:0]        pick_idx_s;
    logic                 valid_s;

    // Search from the pointer and derive grant plus next pointer.
    always_comb begin
        req_ext_s          = '0;
        req_ext_s[N-1:0]   = req_i;
        pick_s             = rr_pick(req_ext_s, IDX_MAX_W'(ptr_q), 32'(N));
        pick_idx_s         = pick_s.idx[IW-1:0];
        valid_s            = en_i & pick_s.found;
        gnt_o              = '0;
        ptr_d              = ptr_q;
        if (valid_s) begin
            gnt_o[pick_idx_s] = 1'b1;
            ptr_d = (pick_idx_s == IW'(N - 1)) ? IW'(0) : (pick_idx_s + IW'(1));
        end else begin
            ptr_d = ptr_q;
        end
        idx_o   = pick_idx_s;
        valid_o = valid_s;
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/ram_sdp_sched.sv
// Scheduler for one simple-dual-port RAM: round-robin writes on port A, reads on
// port B, and a tag pipeline returning read data to the requester that issued it.
module ram_sdp_sched
    import ram_sdp_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MEM_DEPTH   = 64,
    parameter int BYTE_WIDTH  = 8,
    parameter int BYTE_NUM    = 4,
    parameter int RAM_LATENCY = 1,
    parameter int NO_CHANGE   = 1,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int DW = BYTE_WIDTH * BYTE_NUM,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ram_sdp_sched_if.slave      bus,
    output logic                a_en_o,
    output logic [BYTE_NUM-1:0] a_wr_en_o,
    output logic [AW-1:0]       a_addr_o,
    output logic [DW-1:0]       a_data_o,
    output logic                b_en_o,
    output logic [AW-1:0]       b_addr_o,
    input  logic [DW-1:0]       b_data_i
);
    logic          wr_en_s;
    logic          rd_en_s;
    logic          wr_gnt_s;
    logic          rd_gnt_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] rd_idx_s;
    logic          phase_q;
    logic          phase_d;
    tag_t          tag_q [RAM_LATENCY];
    tag_t          tag_d [RAM_LATENCY];
    tag_t          last_s;

    // In no_change mode a contended cycle goes to the side chosen by phase, which then flips.
    always_comb begin
        wr_en_s = !rst_i;
        rd_en_s = !rst_i;
        phase_d = phase_q;
        if ((NO_CHANGE != 0) && (|bus.wr_valid_i) && (|bus.rd_valid_i)) begin
            wr_en_s = !rst_i && !phase_q;
            rd_en_s = !rst_i && phase_q;
            phase_d = !phase_q;
        end else begin
            phase_d = phase_q;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (bus.wr_valid_i),
        .en_i    (wr_en_s),
        .gnt_o   (bus.wr_ready_o),
        .idx_o   (wr_idx_s),
        .valid_o (wr_gnt_s)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (bus.rd_valid_i),
        .en_i    (rd_en_s),
        .gnt_o   (bus.rd_ready_o),
        .idx_o   (rd_idx_s),
        .valid_o (rd_gnt_s)
    );

    // Steer the granted requester onto each RAM port; idle ports drive zero.
    always_comb begin
        a_en_o = wr_gnt_s;
        b_en_o = rd_gnt_s;
        if (wr_gnt_s) begin
            a_wr_en_o = bus.wr_be_i[wr_idx_s*BYTE_NUM +: BYTE_NUM];
            a_addr_o  = bus.wr_addr_i[wr_idx_s*AW +: AW];
            a_data_o  = bus.wr_data_i[wr_idx_s*DW +: DW];
        end else begin
            a_wr_en_o = '0;
            a_addr_o  = '0;
            a_data_o  = '0;
        end
        if (rd_gnt_s) begin
            b_addr_o = bus.rd_addr_i[rd_idx_s*AW +: AW];
        end else begin
            b_addr_o = '0;
        end
    end

    // Tag shift and response decode; the last stage lines up with b_data_i.
    always_comb begin
        tag_d[0].valid = rd_gnt_s;
        tag_d[0].idx   = IDX_MAX_W'(rd_idx_s);
        for (int i = 1; i < RAM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        last_s          = tag_q[RAM_LATENCY-1];
        bus.rsp_valid_o = '0;
        if (last_s.valid && !rst_i) begin
            bus.rsp_valid_o[last_s.idx[IW-1:0]] = 1'b1;
        end else begin
            bus.rsp_valid_o = '0;
        end
        bus.rsp_data_o = rst_i ? '0 : b_data_i;
    end

    // Phase and tag registers; reset drops every read in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end
endmodule

// File: doc/ram_sdp_sched.md
# ram_sdp_sched

Multi-requester scheduler for one `ram_sdp` instance. It arbitrates NUM_REQ write requesters onto port A and NUM_REQ read requesters onto port B using independent round-robin pointers. It tracks every issued read through a tag pipeline matched to the RAM read latency and returns the data to the originating requester. It sits between client engines (DMA, packet buffers) and a shared block/ultra RAM.

## Interface
Parameters:
- NUM_REQ, 4: number of read and of write requesters; must be ≥ 2.
- MEM_DEPTH, 64: RAM depth; address width AW = $clog2(MEM_DEPTH).
- BYTE_WIDTH, 8: bits per byte lane.
- BYTE_NUM, 4: byte lanes; DW = BYTE_WIDTH*BYTE_NUM.
- RAM_LATENCY, 1: cycles from `b_en_o` high to valid `b_data_i`; must be ≥ 1 and equal the attached RAM's effective latency.
- NO_CHANGE, 1: when 1, a read is never issued in the same cycle as a write (RAM in no_change mode); when 0, reads and writes issue concurrently.

Ports (clock and reset first):
- clk_i  in  1  single clock for the block and the RAM.
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  NUM_REQ  per-requester write request.
- wr_ready_o  out  NUM_REQ  one-hot write grant; transfer on valid&ready.
- wr_addr_i  in  NUM_REQ*AW  packed write addresses; requester r at [r*AW+:AW].
- wr_data_i  in  NUM_REQ*DW  packed write data.
- wr_be_i  in  NUM_REQ*BYTE_NUM  packed byte enables.
- rd_valid_i  in  NUM_REQ  per-requester read request.
- rd_ready_o  out  NUM_REQ  one-hot read grant.
- rd_addr_i  in  NUM_REQ*AW  packed read addresses.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle read response strobe.
- rsp_data_o  out  DW  response data; valid only with rsp_valid_o.
- a_en_o / a_wr_en_o / a_addr_o / a_data_o  out  1/BYTE_NUM/AW/DW  RAM port A.
- b_en_o / b_addr_o  out  1/AW  RAM port B.
- b_data_i  in  DW  RAM port B data.

## Operation
- Write arbiter: round-robin over `wr_valid_i`, starting the search at `wr_ptr`. On a grant to requester g:
  - `wr_ready_o[g]`=1 and `a_en_o`=1.
  - `a_wr_en_o`=`wr_be_i[g]`, and the address/data of requester g drive port A.
  - Next cycle `wr_ptr`=(g+1) mod NUM_REQ.
  - A grant with be=0 is still consumed (`a_en_o`=1, `a_wr_en_o`=0).
- Read arbiter: identical scheme with `rd_ptr`, driving `b_en_o` and `b_addr_o`.
- Both arbiters are combinational in the same cycle: ready may depend on valid. Requesters hold valid, addr, data and be until ready.
- NO_CHANGE=1, when both a write and a read are pending:
  - A `phase` bit decides; 0 means write wins, 1 means read wins.
  - `phase` toggles after each contended cycle.
  - Uncontested requests issue immediately and leave `phase` unchanged.
- NO_CHANGE=0: no interlock.
- Tag pipeline: RAM_LATENCY stages of {valid, idx[$clog2(NUM_REQ)-1:0]}, shifted every cycle.
  - Stage 0 loads {b_en_o, granted idx}.
  - When the last stage is valid, `rsp_valid_o[idx]`=1 and `rsp_data_o`=`b_data_i`, both combinational.
- Responses have no backpressure. Requesters must accept them.
- Read-after-write to the same address in one cycle returns old data (NO_CHANGE=0) or cannot occur (NO_CHANGE=1). The scheduler does not forward.

## Timing
- Reset values:
  - All ready/response/RAM-control outputs are 0.
  - `wr_ptr`=`rd_ptr`=0, `phase`=0.
  - All tag stages are invalid.
  - Reads in flight during reset are dropped; no response is emitted for them.
- Write accepted at cycle t reaches the RAM at edge t+1.
- Read accepted at cycle t produces its response at cycle t+RAM_LATENCY.
- Throughput is one read and one write per cycle (NO_CHANGE=0), or one access per cycle (NO_CHANGE=1).
- Pointer wrap: requester NUM_REQ-1 is followed by requester 0.
- `rsp_data_o` is a combinational pass-through of `b_data_i`; it is registered only by the RAM.

## Structure
- Package `ram_sdp_sched_pkg`:
  - `tag_t` struct {valid, idx}.
  - Function `rr_pick(req, ptr)` returning {found, idx}.
- One sub-module `rr_arbiter` (parameter N; ports req, ptr update on grant, one-hot gnt, idx). It is instantiated twice: write and read.
- Tag pipeline and NO_CHANGE interlock live in the top.

## Test plan
- Single read: NUM_REQ=4, RAM_LATENCY=3, preload addr 5 = 0xDEADBEEF; requester 2 reads addr 5 at cycle 10. Required: `rsp_valid_o`=4'b0100 at cycle 13 with data 0xDEADBEEF.
- Round robin: all four rd_valid held high for 8 cycles. Required: grants in order 0,1,2,3,0,1,2,3; responses return in the same order, RAM_LATENCY cycles later.
- NO_CHANGE=1 contention: write req 0 and read req 1 held high. Required: `a_en_o` and `b_en_o` never high together; the write issues first (phase=0), then they alternate W,R,W,R.
- Byte enables: write 0x11223344 to addr 7 with be=4'b1111, then 0xAABBCCDD with be=4'b0101, then read addr 7. Required: read returns 0x11BB33DD.
- Reset mid-flight: issue 3 reads with RAM_LATENCY=4, assert rst_i one cycle later. Required: no rsp_valid_o pulse for those reads; all outputs are 0 while reset is asserted; first grant after reset goes to requester 0.
- NO_CHANGE=0 concurrency: simultaneous write to addr 3 and read from addr 3 in one cycle. Required: both issue; the read returns the pre-write value.
